sseg_scan_scheduler: RTL and testbench
======================================

# sseg_scan_scheduler

Scan controller for the 4-digit seven-segment display on the board. It sequences digit strobes with a programmable on-time and a blanking dead-time between digits to suppress ghosting. It accepts new 16-bit display values through a valid/ready handshake and applies them only at frame boundaries, so a frame never shows mixed old and new digits. It replaces the free-running refresh counter inside the time-multiplexed display top level.

## Interface
- REFRESH_DIV, 25000: cycles a digit is driven per slot; must be ≥1.
- BLANK_CYCLES, 2500: cycles with all anodes off before each digit slot; may be 0, which skips BLANK.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- upd_data  in  16  new display value; [15:12] is digit 3 (leftmost, an[3]), [3:0] is digit 0.
- upd_valid  in  1  upd_data is valid.
- upd_ready  out  1  pending buffer empty; transfer occurs when upd_valid && upd_ready.
- digit_en  in  4  per-digit enable; 0 keeps that anode off for its slot.
- dp_in  in  4  decimal point request per digit, active-high.
- an  out  4  anodes, active-low.
- sseg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse on the last SHOW cycle of digit 3.

## Operation
- Registers: display value (16), pending buffer (16) plus pending flag, digit index (2 bits, 0→1→2→3→0), slot counter, state.
- FSM states:
  - BLANK: an=4'b1111, sseg=7'h7F, dp=1. Lasts BLANK_CYCLES cycles, then goes to SHOW.
  - SHOW: lasts REFRESH_DIV cycles. Drives an[idx]=0 when the digit is shown, sseg=hex decode of the nibble, dp=~dp_in[idx]. On expiry the index advances and the FSM goes to BLANK (or directly to SHOW when BLANK_CYCLES=0).
- A digit is shown when digit_en[idx]=1 and it is not blanked by the optional logic in Configuration. A suppressed digit keeps an=1111, sseg=7'h7F and dp=1 for its slot; slot timing is unchanged.
- Hex decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Handshake:
  - upd_ready = ~pending flag.
  - A transfer loads the pending buffer and sets the flag.
  - On the frame boundary (the cycle frame_tick=1), if the flag is set: display ← pending, flag cleared.
  - A transfer in the frame_tick cycle itself is captured into pending and applied at the following frame boundary.
  - upd_valid while upd_ready=0 is held off; data is not lost and not overwritten.

## Timing
- Reset (reset=0 at a rising edge):
  - an=4'b1111, sseg=7'h7F, dp=1, frame_tick=0, upd_ready=0.
  - display=16'h0000, pending discarded, idx=0, state=BLANK, counter=0.
- upd_ready rises on the first edge after reset goes high.
- Reset mid-frame returns to reset values on the next edge; there is no partial-slot completion.
- All outputs are registered and change on the edge that enters a state.
- Digit period = BLANK_CYCLES+REFRESH_DIV; frame = 4× digit period.
- The first SHOW of digit 0 begins BLANK_CYCLES cycles after reset release.
- Update latency: the new value appears at the first SHOW slot of digit 0 after the next frame_tick.

## Configuration
- SSEG_LZ_BLANK_EN defined: leading-zero blanking.
  - Digits 3..1 are suppressed when their nibble and every higher nibble are 0.
  - Digit 0 is never blanked by this rule.
  - The rule uses the display register, not pending.
- Undefined: every enabled digit is shown, including leading zeros.

## Test plan
All scenarios use REFRESH_DIV=4, BLANK_CYCLES=2 (period 6, frame 24).
- Reset: hold reset=0 for 3 cycles → an=1111, sseg=1111111, dp=1, upd_ready=0. Release → upd_ready=1 next cycle; after 2 BLANK cycles, an=1110 with sseg=1000000 for 4 cycles.
- Update: transfer 16'h1234 mid-frame → old digits persist until frame_tick. The next frame then shows:
  - an=1110 with sseg=0011001 (4)
  - 1101 / 0110000 (3)
  - 1011 / 0100100 (2)
  - 0111 / 1111001 (1)
- Back-pressure: transfer 16'hAAAA, then hold upd_valid with 16'h5555 → upd_ready=0 until frame_tick. AAAA is displayed first, 5555 one frame later, and no value is dropped.
- Leading zeros: display 16'h0070 with SSEG_LZ_BLANK_EN → an[3] and an[2] never low; digit 1 shows 1111000 and digit 0 shows 1000000. Without the macro, digits 3 and 2 show 1000000.
- Enables and dp: digit_en=0101, dp_in=0001 → only an[0] and an[2] ever go low; dp=0 only during digit 0 SHOW; frame_tick period stays 24.
- Reset mid-SHOW of digit 2 with pending set → next edge gives reset values; pending is discarded and the display returns to 0000.

Source files
------------

// File: rtl/sseg_scan_scheduler_if.sv
// Update channel of the seven-segment scan scheduler: 16-bit display value with valid/ready.
interface sseg_scan_scheduler_if;
    logic [15:0] upd_data;
    logic        upd_valid;
    logic        upd_ready;

    modport master (
        output upd_data,
        output upd_valid,
        input  upd_ready
    );

    modport slave (
        input  upd_data,
        input  upd_valid,
        output upd_ready
    );
endinterface

// File: rtl/sseg_scan_scheduler.sv
// 4-digit seven-segment scan controller with blanking dead-time and frame-aligned updates.
// Optional leading-zero blanking is enabled by defining SSEG_LZ_BLANK_EN.
module sseg_scan_scheduler #(
    parameter int unsigned REFRESH_DIV  = 25000,
    parameter int unsigned BLANK_CYCLES = 2500
) (
    input  logic                        clk,
    input  logic                        reset,
    sseg_scan_scheduler_if.slave        upd,
    input  logic [3:0]                  digit_en,
    input  logic [3:0]                  dp_in,
    output logic [3:0]                  an,
    output logic [6:0]                  sseg,
    output logic                        dp,
    output logic                        frame_tick
);

    localparam int unsigned CntMax = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] ShowLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

    typedef enum logic [0:0] {StBlank, StShow} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     disp_q, disp_d;
    logic [15:0]     pbuf_q, pbuf_d;
    logic            pend_q, pend_d;
    logic            ready_q, ready_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      sseg_q, sseg_d;
    logic            dp_q, dp_d;
    logic            tick_q, tick_d;
    logic [3:0]      nib;
    logic            lz;
    logic            shown;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        disp_d  = disp_q;
        pbuf_d  = pbuf_q;
        pend_d  = pend_q;

        unique case (state_q)
            StBlank: begin
                if (BLANK_CYCLES == 0 || cnt_q == BlankLast) begin
                    state_d = StShow;
                    cnt_d   = '0;
                end
            end
            StShow: begin
                if (cnt_q == ShowLast) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    state_d = (BLANK_CYCLES == 0) ? StShow : StBlank;
                end
            end
        endcase

        // Apply pending value on the frame boundary before accepting a new transfer, so a
        // transfer in the tick cycle itself lands in pending for the following frame.
        if (tick_q && pend_q) begin
            disp_d = pbuf_q;
            pend_d = 1'b0;
        end
        if (upd.upd_valid && ready_q) begin
            pbuf_d = upd.upd_data;
            pend_d = 1'b1;
        end
        ready_d = ~pend_d;

        // Outputs are computed from next-state values so they change on the entering edge.
        nib = disp_d[{idx_d, 2'b00} +: 4];
`ifdef SSEG_LZ_BLANK_EN
        unique case (idx_d)
            2'd3:    lz = (disp_d[15:12] == 4'h0);
            2'd2:    lz = (disp_d[15:8] == 8'h00);
            2'd1:    lz = (disp_d[15:4] == 12'h000);
            default: lz = 1'b0;
        endcase
`else
        lz = 1'b0;
`endif
        shown = (state_d == StShow) && digit_en[idx_d] && !lz;

        an_d   = 4'hF;
        sseg_d = 7'h7F;
        dp_d   = 1'b1;
        if (shown) begin
            an_d[idx_d] = 1'b0;
            sseg_d      = hex_decode(nib);
            dp_d        = ~dp_in[idx_d];
        end
        tick_d = (state_d == StShow) && (idx_d == 2'd3) && (cnt_d == ShowLast);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StBlank;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            disp_q  <= 16'h0000;
            pbuf_q  <= 16'h0000;
            pend_q  <= 1'b0;
            ready_q <= 1'b0;
            an_q    <= 4'hF;
            sseg_q  <= 7'h7F;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pbuf_q  <= pbuf_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
        end
    end

    assign upd.upd_ready = ready_q;
    assign an            = an_q;
    assign sseg          = sseg_q;
    assign dp            = dp_q;
    assign frame_tick    = tick_q;

endmodule

// File: tb/tb_sseg_scan_scheduler.sv
// Scoreboard bench for sseg_scan_scheduler: REFRESH_DIV=4, BLANK_CYCLES=2 (period 6, frame 24).
module tb_sseg_scan_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] digit_en = 4'hF;
    logic [3:0] dp_in = 4'h0;
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;
    logic       frame_tick;

    sseg_scan_scheduler_if upd_if ();

    sseg_scan_scheduler #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .upd        (upd_if),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .an         (an),
        .sseg       (sseg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         slot;
        logic [3:0] an;
        logic [6:0] sseg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   t = -1;        // cycles since reset release, updated by the monitor
    bit   prev_rst_low = 1'b0;
    bit   cur_valid = 1'b0;
    exp_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic push_slot(input int slot, input logic [3:0] a, input logic [6:0] s,
                             input logic d);
        exp_t e;
        e.slot = slot;
        e.an   = a;
        e.sseg = s;
        e.dp   = d;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int base, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        push_slot(base + 0, 4'b1110, s0, 1'b1);
        push_slot(base + 1, 4'b1101, s1, 1'b1);
        push_slot(base + 2, 4'b1011, s2, 1'b1);
        push_slot(base + 3, 4'b0111, s3, 1'b1);
    endtask

    // Returns during cycle n, just after the edge that starts it.
    task automatic at_cycle(input int n);
        bit hit = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk);
            if (t == n - 1) begin
                hit = 1'b1;
                break;
            end
        end
        #1;
        chk("at_cycle_reached", 32'(hit), 32'd1);
    endtask

    task automatic xfer(input logic [15:0] data, output int hit_t);
        bit hit = 1'b0;
        hit_t = -1;
        upd_if.upd_data  = data;
        upd_if.upd_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (upd_if.upd_ready) begin
                hit   = 1'b1;
                hit_t = t;
                break;
            end
        end
        @(posedge clk);
        #1;
        upd_if.upd_valid = 1'b0;
        chk("xfer_accepted", 32'(hit), 32'd1);
    endtask

    always @(negedge clk) begin
        int ph;
        int s;
        if (!reset) begin
            if (prev_rst_low) begin
                chk("rst_an", 32'(an), 32'hF);
                chk("rst_sseg", 32'(sseg), 32'h7F);
                chk("rst_dp", 32'(dp), 32'd1);
                chk("rst_tick", 32'(frame_tick), 32'd0);
                chk("rst_ready", 32'(upd_if.upd_ready), 32'd0);
            end
            prev_rst_low = 1'b1;
            t = -1;
            cur_valid = 1'b0;
        end else begin
            prev_rst_low = 1'b0;
            t = t + 1;
            ph = t % 6;
            s = t / 6;
            chk("frame_tick", 32'(frame_tick), 32'((t % 24) == 23));
            if (t == 0) chk("ready_at_release", 32'(upd_if.upd_ready), 32'd0);
            if (t == 1) chk("ready_after_release", 32'(upd_if.upd_ready), 32'd1);
            if (ph < 2) begin
                chk("blank_an", 32'(an), 32'hF);
                chk("blank_sseg", 32'(sseg), 32'h7F);
                chk("blank_dp", 32'(dp), 32'd1);
            end else begin
                if (ph == 2) begin
                    cur_valid = 1'b0;
                    while (exp_q.size() > 0 && exp_q[0].slot < s) begin
                        void'(exp_q.pop_front());
                        chk("slot_missed", 32'(s), 32'hFFFF_FFFF);
                    end
                    if (exp_q.size() > 0 && exp_q[0].slot == s) begin
                        cur = exp_q.pop_front();
                        cur_valid = 1'b1;
                    end
                end
                if (cur_valid) begin
                    chk("show_an", 32'(an), 32'(cur.an));
                    chk("show_sseg", 32'(sseg), 32'(cur.sseg));
                    chk("show_dp", 32'(dp), 32'(cur.dp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int ht;
        upd_if.upd_valid = 1'b0;
        upd_if.upd_data  = 16'h0000;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        push_frame(0, 7'h40, 7'h40, 7'h40, 7'h40);

        // 1234 transferred mid-frame 0, shown from frame 1.
        at_cycle(10);
        xfer(16'h1234, ht);
        push_frame(4, 7'h19, 7'h30, 7'h24, 7'h79);
        push_frame(8, 7'h19, 7'h30, 7'h24, 7'h79);

        // Back-pressure: 5555 is held off until the tick that applies AAAA.
        at_cycle(50);
        xfer(16'hAAAA, ht);
        push_frame(12, 7'h08, 7'h08, 7'h08, 7'h08);
        push_frame(16, 7'h12, 7'h12, 7'h12, 7'h12);
        xfer(16'h5555, ht);
        chk("backpressure_accept_cycle", 32'(ht), 32'd72);

        at_cycle(100);
        xfer(16'h0070, ht);
        push_slot(20, 4'b1110, 7'h40, 1'b1);
        push_slot(21, 4'b1101, 7'h78, 1'b1);
`ifdef SSEG_LZ_BLANK_EN
        push_slot(22, 4'b1111, 7'h7F, 1'b1);
        push_slot(23, 4'b1111, 7'h7F, 1'b1);
`else
        push_slot(22, 4'b1011, 7'h40, 1'b1);
        push_slot(23, 4'b0111, 7'h40, 1'b1);
`endif

        at_cycle(125);
        xfer(16'h8C5E, ht);

        // Enables 0101 and dp on digit 0 for frame 6.
        at_cycle(143);
        digit_en = 4'b0101;
        dp_in    = 4'b0001;
        push_slot(24, 4'b1110, 7'h06, 1'b0);
        push_slot(25, 4'b1111, 7'h7F, 1'b1);
        push_slot(26, 4'b1011, 7'h46, 1'b1);
        push_slot(27, 4'b1111, 7'h7F, 1'b1);

        at_cycle(167);
        digit_en = 4'b1111;
        dp_in    = 4'b0000;
        push_slot(28, 4'b1110, 7'h06, 1'b1);
        push_slot(29, 4'b1101, 7'h12, 1'b1);
        push_slot(30, 4'b1011, 7'h46, 1'b1);

        at_cycle(170);
        xfer(16'hBEEF, ht);

        // Reset during digit 2 SHOW with BEEF pending: pending must be discarded.
        at_cycle(183);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        push_frame(0, 7'h40, 7'h40, 7'h40, 7'h40);
        push_frame(4, 7'h40, 7'h40, 7'h40, 7'h40);

        at_cycle(50);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
